alu_dispatch: RTL and testbench

- Issue/collect sequencer on the request side of the ALU result mux.
- Accepts one operation request (3-bit unit select plus two operands) over a valid/ready handshake and pulses a start strobe to the selected functional unit.
- Drives the 3-bit select of the downstream 8:1 result mux and captures that mux's output when the selected unit signals done.
- Returns the result over a valid/ready response handshake, with a timeout if the unit never completes.

---
 rtl/alu_dispatch_pkg.sv | 22 ++
 rtl/alu_dispatch_if.sv | 27 ++
 rtl/alu_dispatch_timer.sv | 39 +++
 rtl/alu_dispatch.sv | 131 +++++++++++++
 tb/tb_alu_dispatch.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_dispatch_pkg.sv
// Shared types and helpers for the ALU issue/collect sequencer.
package alu_dispatch_pkg;

    localparam int NUM_UNITS = 8;
    localparam int CTRL_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Decode a unit index into its one-hot start/done bit position.
    function automatic logic [NUM_UNITS-1:0] unit_onehot(input logic [CTRL_W-1:0] ctrl);
        logic [NUM_UNITS-1:0] vec;
        vec       = '0;
        vec[ctrl] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/alu_dispatch_if.sv
// Request/response handshake bundle between a requester and the ALU dispatcher.
interface alu_dispatch_if
    import alu_dispatch_pkg::*;
#(
    parameter int N = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [CTRL_W-1:0] req_control;
    logic [N-1:0]      req_a;
    logic [N-1:0]      req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [N-1:0]      rsp_result;
    logic              rsp_timeout;

    modport master (
        output req_valid, req_control, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_timeout
    );

    modport slave (
        input  req_valid, req_control, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_timeout
    );

endinterface

// File: rtl/alu_dispatch_timer.sv
// Wait-cycle counter for the dispatcher: clear, count-enable, terminal flag at TIMEOUT-1.
module dispatch_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
    localparam logic [W-1:0] SAT  = W'(TIMEOUT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear has priority, counting saturates rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != SAT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/alu_dispatch.sv
// Issue/collect sequencer: accepts one ALU op, starts the selected unit,
// steers the result mux, captures the result (or times out) and returns it.
module alu_dispatch
    import alu_dispatch_pkg::*;
#(
    parameter int N       = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_dispatch_if.slave        bus,
    output logic [NUM_UNITS-1:0] unit_start,
    output logic [N-1:0]         unit_a,
    output logic [N-1:0]         unit_b,
    input  logic [NUM_UNITS-1:0] unit_done,
    output logic [CTRL_W-1:0]    mux_sel,
    input  logic [N-1:0]         mux_result
);
    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] ISSUE = ST_ISSUE;
    localparam logic [1:0] WAIT  = ST_WAIT;
    localparam logic [1:0] RESP  = ST_RESP;

    logic [1:0]        state_q,  state_d;
    logic [CTRL_W-1:0] ctrl_q,   ctrl_d;
    logic [N-1:0]      a_q,      a_d;
    logic [N-1:0]      b_q,      b_d;
    logic [N-1:0]      result_q, result_d;
    logic              tmo_q,    tmo_d;

    logic done_sel;
    logic tmr_clr;
    logic tmr_en;
    logic tmr_tc;

    // Only the latched unit's done bit matters; all others are ignored.
    assign done_sel = unit_done[ctrl_q];

    dispatch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (tmr_clr),
        .en_i  (tmr_en),
        .tc_o  (tmr_tc)
    );

    // Sequencer next-state and capture logic; done beats timer expiry.
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        tmo_d    = tmo_q;
        tmr_clr  = 1'b0;
        tmr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    ctrl_d  = bus.req_control;
                    a_d     = bus.req_a;
                    b_d     = bus.req_b;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                tmr_clr = 1'b1;
                if (done_sel) begin
                    result_d = mux_result;
                    tmo_d    = 1'b0;
                    state_d  = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (done_sel) begin
                    result_d = mux_result;
                    tmo_d    = 1'b0;
                    state_d  = RESP;
                end else if (tmr_tc) begin
                    result_d = '0;
                    tmo_d    = 1'b1;
                    state_d  = RESP;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched request and captured response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ctrl_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            tmo_q    <= tmo_d;
        end
    end

    // Start strobe decodes straight from state so reset kills it without a clock edge.
    assign unit_start      = (state_q == ISSUE) ? unit_onehot(ctrl_q) : '0;
    assign unit_a          = a_q;
    assign unit_b          = b_q;
    assign mux_sel         = ctrl_q;
    assign bus.req_ready   = (state_q == IDLE);
    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.rsp_result  = result_q;
    assign bus.rsp_timeout = tmo_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch with a response scoreboard.
module tb_alu_dispatch;
    localparam int N       = 8;
    localparam int TIMEOUT = 15;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   unit_start;
    logic [N-1:0] unit_a;
    logic [N-1:0] unit_b;
    logic [7:0]   unit_done;
    logic [2:0]   mux_sel;
    logic [N-1:0] mux_result;

    alu_dispatch_if #(.N(N)) bus ();

    alu_dispatch #(
        .N       (N),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .unit_start (unit_start),
        .unit_a     (unit_a),
        .unit_b     (unit_b),
        .unit_done  (unit_done),
        .mux_sel    (mux_sel),
        .mux_result (mux_result)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [N-1:0] res;
        logic         tmo;
    } exp_t;

    exp_t sb[$];

    // Sweep table: per-unit operands and the hand-chosen result each unit returns.
    logic [7:0] sw_a   [8] = '{8'h01, 8'h12, 8'h23, 8'h34, 8'h45, 8'h56, 8'h67, 8'h78};
    logic [7:0] sw_b   [8] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    logic [7:0] sw_res [8] = '{8'h11, 8'h32, 8'h53, 8'h74, 8'h95, 8'hB6, 8'hD7, 8'hF8};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every response handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rsp_unexpected: got result %0h with no request outstanding, expected none",
                         bus.rsp_result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_result", {24'h0, bus.rsp_result}, {24'h0, e.res});
                check("rsp_timeout", {31'h0, bus.rsp_timeout}, {31'h0, e.tmo});
            end
        end
    end

    // One full operation. dly = cycle index after acceptance (0 = ISSUE) on which
    // the unit signals done; dly > TIMEOUT means never. hold = cycles rsp_ready stays low.
    task automatic run_op(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] res, input int dly, input logic [7:0] noise,
                          input int hold, input bit pend, input logic [2:0] pc,
                          input logic [7:0] pa, input logic [7:0] pb);
        int         lat;
        int         exp_lat;
        bit         exp_tmo;
        bit         bad;
        int         guard;
        logic [7:0] oh;
        logic [7:0] exp_res;
        exp_t       ex;

        oh = 8'(1) << c;
        bus.req_control = c;
        bus.req_a       = a;
        bus.req_b       = b;
        bus.req_valid   = 1'b1;
        guard = 0;
        while (!bus.req_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("req_ready_before_accept", {31'h0, bus.req_ready}, 32'd1);
        @(posedge clk);
        exp_tmo = (dly > TIMEOUT);
        exp_lat = exp_tmo ? TIMEOUT + 1 : dly + 1;
        exp_res = exp_tmo ? 8'h00 : res;
        ex.res  = exp_res;
        ex.tmo  = exp_tmo;
        sb.push_back(ex);
        #1;
        bus.req_valid = 1'b0;

        lat = -1;
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.rsp_valid) begin
                lat = i;
                break;
            end
            if (i == 0) begin
                check("unit_start_onehot", {24'h0, unit_start}, {24'h0, oh});
                check("unit_a", {24'h0, unit_a}, {24'h0, a});
                check("unit_b", {24'h0, unit_b}, {24'h0, b});
            end
            if (i == 1) check("unit_start_one_cycle", {24'h0, unit_start}, 32'h0);
            if (mux_sel !== c) bad = 1'b1;
            unit_done  = (i == dly) ? oh : (noise & ~oh);
            mux_result = (i == dly) ? res : ~res;
            @(posedge clk);
            #1;
        end
        unit_done  = 8'h00;
        mux_result = 8'hEE;
        check("rsp_latency", lat, exp_lat);
        check("mux_sel_held", {31'h0, bad}, 32'd0);

        if (pend) begin
            bus.req_control = pc;
            bus.req_a       = pa;
            bus.req_b       = pb;
            bus.req_valid   = 1'b1;
        end
        bad = 1'b0;
        for (int h = 0; h < hold; h++) begin
            if (!bus.rsp_valid || bus.rsp_result !== exp_res || bus.rsp_timeout !== exp_tmo ||
                bus.req_ready || unit_start !== 8'h00 || mux_sel !== c) bad = 1'b1;
            @(posedge clk);
            #1;
        end
        if (hold > 0) check("backpressure_stable", {31'h0, bad}, 32'd0);

        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check("rsp_valid_drop", {31'h0, bus.rsp_valid}, 32'd0);
        check("req_ready_after_rsp", {31'h0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        bus.req_valid   = 1'b0;
        bus.req_control = 3'd0;
        bus.req_a       = 8'h00;
        bus.req_b       = 8'h00;
        bus.rsp_ready   = 1'b0;
        unit_done       = 8'h00;
        mux_result      = 8'h00;
        rst_n           = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_req_ready", {31'h0, bus.req_ready}, 32'd1);
        check("reset_rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
        check("reset_unit_start", {24'h0, unit_start}, 32'h0);
        check("reset_mux_sel", {29'h0, mux_sel}, 32'h0);
        check("reset_rsp_result", {24'h0, bus.rsp_result}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-cycle unit.
        run_op(3'd3, 8'h12, 8'h34, 8'h46, 0, 8'h00, 0, 1'b0, 3'd0, 8'h00, 8'h00);
        // Multi-cycle unit with a stray done on unit 2.
        run_op(3'd7, 8'hA0, 8'h0B, 8'hC3, 4, 8'h04, 0, 1'b0, 3'd0, 8'h00, 8'h00);
        // Timeout: unit never completes.
        run_op(3'd5, 8'h55, 8'h66, 8'h77, 99, 8'h00, 0, 1'b0, 3'd0, 8'h00, 8'h00);
        // Done on the final timer cycle wins over expiry.
        run_op(3'd5, 8'h01, 8'h02, 8'h5A, TIMEOUT, 8'h00, 0, 1'b0, 3'd0, 8'h00, 8'h00);
        // Backpressure with a pending request, then that request.
        run_op(3'd1, 8'h21, 8'h43, 8'h64, 1, 8'h00, 5, 1'b1, 3'd2, 8'h0F, 8'h0E);
        run_op(3'd2, 8'h0F, 8'h0E, 8'h1D, 2, 8'h00, 0, 1'b0, 3'd0, 8'h00, 8'h00);
        // Sweep all units back-to-back.
        for (int k = 0; k < 8; k++) begin
            run_op(3'(k), sw_a[k], sw_b[k], sw_res[k], k % 3, 8'h00, 0, 1'b0, 3'd0, 8'h00, 8'h00);
        end

        // Reset while a unit is being started.
        bus.req_control = 3'd6;
        bus.req_a       = 8'h99;
        bus.req_b       = 8'h88;
        bus.req_valid   = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("rst_pre_unit_start", {24'h0, unit_start}, 32'h40);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_unit_start", {24'h0, unit_start}, 32'h0);
        check("rst_async_rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
        check("rst_async_unit_a", {24'h0, unit_a}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release_req_ready", {31'h0, bus.req_ready}, 32'd1);
        check("rst_release_mux_sel", {29'h0, mux_sel}, 32'h0);
        check("rst_release_rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);

        // Normal operation after reset; dropped op must not produce a response.
        run_op(3'd4, 8'h3C, 8'h0C, 8'h48, 2, 8'h00, 0, 1'b0, 3'd0, 8'h00, 8'h00);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
